// File: rtl/shiftreg_sipo_mc.sv
// shiftreg_sipo_mc: multi-channel serial-in/parallel-out shift register with a valid/ready output stage.
// Define SHIFTREG_PARITY_EN to add a trailing even-parity bit per lane and per-lane parity error flags.
module shiftreg_sipo_mc #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset_ni,
  input  logic                         trigger,
  input  logic                         shift_en,
  input  logic [CHANNELS-1:0]          din_serial,
  input  logic [CNT_W-1:0]             len_i,
  input  logic                         lsb_first_i,
  output logic [CHANNELS*WIDTH-1:0]    dout_parallel,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         busy_o,
  output logic [CNT_W-1:0]             bit_cnt_o,
  output logic [15:0]                  frame_cnt_o,
  output logic                         overrun_o,
  input  logic                         ovr_clr,
  output logic [CHANNELS-1:0]          parity_err_o
);

`ifdef SHIFTREG_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t                           state;
  logic [CHANNELS-1:0][WIDTH-1:0]   sr;
  logic [CHANNELS-1:0][WIDTH-1:0]   sr_shift_c;
  logic [CHANNELS-1:0][WIDTH-1:0]   load_data_c;
  logic [CNT_W-1:0]                 bit_cnt;
  logic [CNT_W-1:0]                 bit_cnt_inc_c;
  logic [CNT_W-1:0]                 len_q;
  logic [CNT_W-1:0]                 len_eff_c;
  logic                             lsb_q;
  logic                             last_bit_c;
  logic                             complete_c;
  logic                             load_c;
  logic                             drop_c;
`ifdef SHIFTREG_PARITY_EN
  logic [CHANNELS-1:0]              perr_c;
  logic [CHANNELS-1:0]              perr_q;
`endif

  assign bit_cnt_o = bit_cnt;

  // Next shift-register contents, completion detection and output-stage decisions.
  always_comb begin
    len_eff_c = len_i;
    if (len_i == '0 || len_i > CNT_W'(WIDTH)) len_eff_c = CNT_W'(WIDTH);
    bit_cnt_inc_c = bit_cnt + CNT_W'(1);
    last_bit_c    = shift_en && (bit_cnt_inc_c == len_q);
    sr_shift_c    = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (lsb_q) sr_shift_c[c] = sr[c] | (WIDTH'(din_serial[c]) << bit_cnt);
      else       sr_shift_c[c] = {sr[c][WIDTH-2:0], din_serial[c]};
    end
`ifdef SHIFTREG_PARITY_EN
    perr_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) perr_c[c] = (^sr[c]) ^ din_serial[c];
    complete_c  = (state == PARITY) && shift_en;
    load_data_c = sr;
`else
    complete_c  = (state == SHIFT) && last_bit_c;
    load_data_c = sr_shift_c;
`endif
    load_c = complete_c && (!dout_valid || dout_ready);
    drop_c = complete_c && !load_c;
  end

  // Frame FSM plus the double-buffered output register.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= IDLE;
      sr            <= '0;
      bit_cnt       <= '0;
      len_q         <= '0;
      lsb_q         <= 1'b0;
      dout_parallel <= '0;
      dout_valid    <= 1'b0;
      busy_o        <= 1'b0;
      frame_cnt_o   <= '0;
      overrun_o     <= 1'b0;
`ifdef SHIFTREG_PARITY_EN
      perr_q        <= '0;
`endif
    end else begin
      if (load_c) begin
        dout_parallel <= load_data_c;
        dout_valid    <= 1'b1;
        frame_cnt_o   <= frame_cnt_o + 16'd1;
`ifdef SHIFTREG_PARITY_EN
        perr_q        <= perr_c;
`endif
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end

      // A drop on the same edge as a clear keeps the flag set.
      if (drop_c)       overrun_o <= 1'b1;
      else if (ovr_clr) overrun_o <= 1'b0;

      if (complete_c) begin
        state  <= IDLE;
        busy_o <= 1'b0;
`ifndef SHIFTREG_PARITY_EN
        sr      <= sr_shift_c;
        bit_cnt <= bit_cnt_inc_c;
`endif
      end else if (trigger) begin
        state   <= SHIFT;
        busy_o  <= 1'b1;
        sr      <= '0;
        bit_cnt <= '0;
        len_q   <= len_eff_c;
        lsb_q   <= lsb_first_i;
      end else if (state == SHIFT && shift_en) begin
        sr      <= sr_shift_c;
        bit_cnt <= bit_cnt_inc_c;
`ifdef SHIFTREG_PARITY_EN
        if (last_bit_c) state <= PARITY;
`endif
      end
    end
  end

`ifdef SHIFTREG_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = '0;
`endif

endmodule

// File: doc/shiftreg_sipo_mc.md
Name: shiftreg_sipo_mc

Overview:
Parametrised multi-channel serial-in/parallel-out shift register. It is the next generation of the single-channel shift register in top_system.
- Captures CHANNELS serial lanes in lock-step, started by a trigger.
- Frame length and bit order are runtime-configurable.
- Completed words are delivered through a valid/ready output register that is double-buffered against the shift stage.
- Sits between the stimulus/trigger logic and the parallel consumer. The analyzer callback probes trigger, din_serial and dout_parallel.

Parameters:
WIDTH, 24, max bits per channel per frame (>=2)
CHANNELS, 4, number of serial lanes (>=1)
CNT_W, $clog2(WIDTH+1), width of bit counter / length field (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
reset_ni  in  1  asynchronous reset, active low
trigger  in  1  start-of-frame strobe
shift_en  in  1  bit strobe; lanes sampled on edges where high
din_serial  in  CHANNELS  one serial bit per lane
len_i  in  CNT_W  frame length in bits; 0 or >WIDTH means WIDTH
lsb_first_i  in  1  0: MSB-first, 1: LSB-first
dout_parallel  out  CHANNELS*WIDTH  lane c at [c*WIDTH +: WIDTH]
dout_valid  out  1  dout_parallel holds an undelivered frame
dout_ready  in  1  consumer accepts frame
busy_o  out  1  frame in progress
bit_cnt_o  out  CNT_W  bits captured in current frame
frame_cnt_o  out  16  delivered-frame counter
overrun_o  out  1  sticky: frame dropped because output was full
ovr_clr  in  1  clears overrun_o
parity_err_o  out  CHANNELS  per-lane parity error (see Optional Feature)

Behaviour:
- Reset, asynchronous: all outputs 0, shift registers 0, FSM in IDLE.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- IDLE:
  - trigger=1 -> SHIFT; clear shift regs and bit_cnt.
  - Latch effective length L and lsb_first_i at this edge.
  - The trigger edge does not sample data.
- SHIFT:
  - On each shift_en=1 edge, bit_cnt increments.
  - MSB-first: sr_c <= {sr_c[WIDTH-2:0], din_serial[c]}. After L bits the frame is right-aligned in the low L bits; upper bits are 0.
  - LSB-first: bit k is written to sr_c[k].
  - shift_en=0 holds state.
- Completion: the edge sampling bit L is the completion edge.
  - If the output register is free, or dout_ready=1 on that edge: load dout_parallel, set dout_valid, increment frame_cnt_o (wraps 0xFFFF->0).
  - Otherwise: drop the frame, set overrun_o, leave dout_parallel unchanged.
  - FSM -> IDLE on the completion edge.
  - dout_valid is visible in the cycle after the final bit; latency = 1 clk.
- Handshake:
  - dout_valid falls on the edge where dout_ready=1, unless a new frame loads on the same edge, in which case it stays 1 with new data.
  - dout_parallel is stable while dout_valid=1 and dout_ready=0.
- trigger during SHIFT: partial frame discarded; restart as from IDLE (re-latch L and order); no overrun; frame_cnt unchanged.
- trigger on the completion edge: the frame completes and the FSM goes to IDLE; the trigger is ignored.
- overrun_o: sticky until an ovr_clr edge. If set and clear occur on the same edge, set wins.
- busy_o = (state != IDLE). bit_cnt_o holds its final value in IDLE until the next trigger.

Optional Feature:
SHIFTREG_PARITY_EN
- Defined:
  - After L data bits the FSM enters PARITY.
  - The next shift_en edge samples one parity bit per lane. That edge becomes the completion edge.
  - parity_err_o[c] = XOR of the L data bits and the parity bit of lane c (even parity). It is loaded together with dout_parallel.
  - trigger in PARITY aborts the frame, as in SHIFT.
- Undefined: no PARITY state; parity_err_o tied to 0.

Test Plan:
- Reset, then trigger with L=24, MSB-first; lane0 shifts 0xA5C3F0 (MSB first). Expect dout_parallel[23:0]=0xA5C3F0, dout_valid=1 one clk after bit 24, frame_cnt_o=1.
- L=8, LSB-first; lane1 shifts bits 1,0,0,0,0,0,0,0. Expect lane1 word=0x000001, busy_o=0 after completion, bit_cnt_o=8.
- Two 4-bit frames with dout_ready=0 throughout. Expect first data held, overrun_o=1, frame_cnt_o=1. Then ovr_clr and a set event on the same edge: overrun_o stays 1.
- Completion coincides with dout_ready=1 while dout_valid=1. Expect new data loaded, dout_valid stays 1, overrun_o=0.
- Trigger mid-frame after 10 bits, then a full frame with L=0. Expect a 24-bit frame; partial data absent.
- With SHIFTREG_PARITY_EN: L=8, data 0x07, parity bit 0. Expect parity_err_o[0]=1. Data 0x03, parity 0: expect 0.
